csa_accum_resolve: RTL and testbench
====================================

// Module: csa_accum_resolve
// PURPOSE
//  Downstream stage of the HA/FA compressor tree. Accepts the tree's carry-save
//  pair (SUM_IN, CARRY_IN, already weight-aligned) and accumulates successive
//  pairs in carry-save form using a 4:2 FA row, so no carry propagates per beat.
//  On the LAST beat it resolves the accumulator with a 2-cycle split
//  carry-propagate adder and presents a binary result over a valid/ready port.
// PARAMETERS
//  W       16  width of SUM_IN / CARRY_IN from the compressor tree
//  G       4   guard bits; accumulator width AW = W+G; 2**G beats never overflow
//  SIGNED  0   1: sign-extend inputs to AW (two's complement); 0: zero-extend
// PORTS
//  CLK        in   1    clock, all state on rising edge
//  RST_N      in   1    synchronous reset, active low
//  SUM_IN     in   W    sum vector from compressor tree
//  CARRY_IN   in   W    carry vector from compressor tree (pre-shifted)
//  LAST       in   1    qualifies final beat of an accumulation
//  IN_VALID   in   1    input beat valid
//  IN_READY   out  1    stage can accept a beat
//  OUT_DATA   out  AW   resolved accumulation result, mod 2**AW
//  OUT_OVF    out  1    beat count of this result exceeded 2**G
//  OUT_VALID  out  1    OUT_DATA/OUT_OVF valid
//  OUT_READY  in   1    consumer accepts result
// BEHAVIOUR
//  - Reset (RST_N=0 at edge): state=ACCUM, ACC_S=ACC_C=0, beat count=0,
//    OUT_DATA=0, OUT_OVF=0, OUT_VALID=0. IN_READY forced 0 while RST_N=0.
//  - States: ACCUM -> R_LO -> R_HI -> DONE -> ACCUM.
//  - IN_READY = (state==ACCUM). Beat accepted when IN_VALID & IN_READY.
//  - Accept: ext(x) per SIGNED to AW bits. Row1 FA(ACC_S,ACC_C,ext(SUM_IN))
//    -> s1,c1; row2 FA(s1,c1<<1,ext(CARRY_IN)) -> s2,c2; ACC_S<=s2,
//    ACC_C<=c2<<1, all truncated to AW (wrap mod 2**AW). count<=count+1,
//    saturating at 2**G+1. LAST=1 on accepted beat -> R_LO; else stay ACCUM.
//  - R_LO: low half L=AW/2 bits: {cy,lo} = ACC_S[L-1:0]+ACC_C[L-1:0];
//    register lo and cy. -> R_HI unconditionally.
//  - R_HI: hi = ACC_S[AW-1:L]+ACC_C[AW-1:L]+cy (carry-out dropped);
//    OUT_DATA<={hi,lo}; OUT_OVF<=(count>2**G); OUT_VALID<=1. -> DONE.
//  - Latency: LAST handshake in cycle t -> OUT_VALID=1 in cycle t+3.
//  - DONE: OUT_DATA/OUT_OVF/OUT_VALID held stable until OUT_READY=1; on that
//    edge OUT_VALID<=0, ACC_S=ACC_C=0, count=0, state->ACCUM; IN_READY=1 the
//    following cycle. OUT_DATA retains last value after handshake.
//  - IN_VALID ignored outside ACCUM; no input is dropped (held upstream).
//  - LAST on first beat is legal (single-term result).
//  - Reset in any state, incl. R_LO/R_HI/DONE: discards partial/pending
//    result, returns to reset values next cycle.
//  - OUT_READY while OUT_VALID=0 has no effect.
// STRUCTURE
//  - Shared package/header fmdsp_pkg: state encodings (ACCUM,R_LO,R_HI,DONE,
//    2-bit), AW derivation macro, sign-extend helper function.
//  - Sub-module csa_4to2_row #(AW): two ranks of FA cells, purely
//    combinational; instantiated once for the accumulate step.
//  - CPA halves behavioural '+' in this module; FSM, counter, output regs here.
// TESTING  (W=8, G=4, AW=12 unless stated)
//  1 Reset: RST_N=0 2 cycles, IN_VALID=1 -> IN_READY=0, OUT_VALID=0,
//    OUT_DATA=0; after release IN_READY=1 next cycle.
//  2 Single beat SUM_IN=8'h05, CARRY_IN=8'h0A, LAST=1 at t -> OUT_VALID=1 at
//    t+3, OUT_DATA=12'h00F, OUT_OVF=0.
//  3 Four beats SUM_IN=8'hFF, CARRY_IN=8'h01, LAST on 4th -> OUT_DATA=12'h400,
//    carries crossing the L=6 split boundary verified.
//  4 SIGNED=1: SUM_IN=8'hFE, CARRY_IN=8'h01, LAST -> OUT_DATA=12'hFFF; 16 beats
//    of 8'h80/8'h00 -> 12'h800, OUT_OVF=0.
//  5 Backpressure: OUT_READY=0 for 5 cycles in DONE -> OUT_DATA stable,
//    IN_READY=0, IN_VALID ignored; OUT_READY=1 -> next beat accepted 1 cycle later.
//  6 17 beats of 8'hFF/8'h00 -> OUT_OVF=1, OUT_DATA=12'h0EF (17*255 mod 4096);
//    reset asserted in R_HI of next run -> OUT_VALID stays 0, accumulator zero.

Source files
------------

// File: rtl/fmdsp_pkg.sv
// Shared definitions for the compressor-tree back end: resolve FSM encoding,
// accumulator width derivation and input sign/zero extension.
package fmdsp_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    R_LO  = 2'd1,
    R_HI  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int EXT_MAX = 64;

  // Accumulator width: tree width plus guard bits.
  function automatic int acc_width(input int w, input int g);
    return w + g;
  endfunction

  // Extend the low w bits of x to EXT_MAX bits; sgn selects two's complement.
  function automatic logic [EXT_MAX-1:0] ext_to(input logic [EXT_MAX-1:0] x,
                                                input int w, input logic sgn);
    logic [EXT_MAX-1:0] r;
    r = x;
    for (int i = 0; i < EXT_MAX; i++) begin
      if (i >= w) r[i] = sgn & x[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/csa_4to2_row.sv
// Two ranks of full adders reducing four aligned vectors to a carry-save pair.
// Latency: combinational. Backpressure: none, pure logic.
// The returned carry is already shifted to its weight and truncated to AW bits.
module csa_4to2_row #(
  parameter int AW = 20
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  input  logic [AW-1:0] c,
  input  logic [AW-1:0] d,
  output logic [AW-1:0] s,
  output logic [AW-1:0] cy
);

  logic [AW-1:0] s1, c1, c1w, c2;

  assign s1  = a ^ b ^ c;
  assign c1  = (a & b) | (a & c) | (b & c);
  assign c1w = {c1[AW-2:0], 1'b0};

  assign s   = s1 ^ c1w ^ d;
  assign c2  = (s1 & c1w) | (s1 & d) | (c1w & d);
  assign cy  = {c2[AW-2:0], 1'b0};

endmodule

// File: rtl/csa_accum_resolve.sv
// Accumulates compressor-tree carry-save pairs, then resolves them with a split CPA.
// Latency: LAST handshake in cycle t gives out_valid in cycle t+3.
// Backpressure: in_ready only in ACCUM; the result is held in DONE until out_ready.
module csa_accum_resolve
  import fmdsp_pkg::*;
#(
  parameter int W      = 16,
  parameter int G      = 4,
  parameter int SIGNED = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [W-1:0]                sum_in,
  input  logic [W-1:0]                carry_in,
  input  logic                        last,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [acc_width(W,G)-1:0]   out_data,
  output logic                        out_ovf,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int AW = acc_width(W, G);
  localparam int L  = AW / 2;
  localparam int H  = AW - L;
  localparam int CW = G + 1;
  localparam logic [CW-1:0] CNT_LIM = CW'(2**G);
  localparam logic [CW-1:0] CNT_SAT = CW'(2**G + 1);

  state_t        state, state_nx;
  logic [AW-1:0] acc_s, acc_c;
  logic [AW-1:0] ext_sum, ext_carry;
  logic [AW-1:0] csa_s, csa_c;
  logic [CW-1:0] cnt;
  logic [L-1:0]  lo_r;
  logic          cy_r;
  logic [H-1:0]  hi_sum;
  logic          accept;

  assign ext_sum   = AW'(ext_to(EXT_MAX'(sum_in),   W, SIGNED != 0));
  assign ext_carry = AW'(ext_to(EXT_MAX'(carry_in), W, SIGNED != 0));

  csa_4to2_row #(.AW(AW)) u_row (
    .a  (acc_s),
    .b  (acc_c),
    .c  (ext_sum),
    .d  (ext_carry),
    .s  (csa_s),
    .cy (csa_c)
  );

  assign accept = in_valid & in_ready;

  // Upper CPA half; carry-out beyond AW is intentionally discarded.
  assign hi_sum = acc_s[AW-1:L] + acc_c[AW-1:L] + {{(H-1){1'b0}}, cy_r};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = rst_n;
        if (in_valid && rst_n && last) state_nx = R_LO;
      end
      R_LO: state_nx = R_HI;
      R_HI: state_nx = DONE;
      DONE: if (out_ready) state_nx = ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_s     <= '0;
      acc_c     <= '0;
      cnt       <= '0;
      lo_r      <= '0;
      cy_r      <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc_s <= csa_s;
            acc_c <= csa_c;
            if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
          end
        end
        R_LO: {cy_r, lo_r} <= {1'b0, acc_s[L-1:0]} + {1'b0, acc_c[L-1:0]};
        R_HI: begin
          out_data  <= {hi_sum, lo_r};
          out_ovf   <= (cnt > CNT_LIM);
          out_valid <= 1'b1;
        end
        DONE: begin
          // Clearing here lets the next accumulation start from zero immediately.
          if (out_ready) begin
            out_valid <= 1'b0;
            acc_s     <= '0;
            acc_c     <= '0;
            cnt       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum_resolve.sv
// Directed bench: one unsigned and one signed instance share all stimulus.
module tb_csa_accum_resolve;

  localparam int W  = 8;
  localparam int G  = 4;
  localparam int AW = W + G;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  sum_in, carry_in;
  logic          last, in_valid, out_ready;
  logic          in_ready, out_ovf, out_valid;
  logic [AW-1:0] out_data;
  logic          in_ready_s, out_ovf_s, out_valid_s;
  logic [AW-1:0] out_data_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  csa_accum_resolve #(.W(W), .G(G), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .carry_in(carry_in),
    .last(last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  csa_accum_resolve #(.W(W), .G(G), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .carry_in(carry_in),
    .last(last), .in_valid(in_valid), .in_ready(in_ready_s),
    .out_data(out_data_s), .out_ovf(out_ovf_s), .out_valid(out_valid_s),
    .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one beat from a post-edge point; returns just after the accepting edge.
  task automatic beat(input logic [W-1:0] s, input logic [W-1:0] c, input logic l);
    sum_in   = s;
    carry_in = c;
    last     = l;
    in_valid = 1'b1;
    #1;
    chk("beat_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    last     = 1'b0;
  endtask

  // Called right after the LAST handshake edge; checks t+3 latency and the result.
  task automatic expect_result(input string tag, input logic [AW-1:0] d,
                               input logic ovf, input logic [AW-1:0] ds);
    chk({tag, "_vld_t1"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_vld_t2"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_vld_t3"}, out_valid, 1);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_ovf"}, out_ovf, ovf);
    chk({tag, "_vld_s"}, out_valid_s, 1);
    chk({tag, "_data_s"}, out_data_s, ds);
    chk({tag, "_ovf_s"}, out_ovf_s, ovf);
    chk({tag, "_rdy_done"}, in_ready, 0);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_vld_clr"}, out_valid, 0);
    chk({tag, "_rdy_back"}, in_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    sum_in    = 8'h55;
    carry_in  = 8'h11;
    last      = 1'b1;
    out_ready = 1'b0;

    // Reset with in_valid asserted
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready_s", in_ready_s, 0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    last     = 1'b0;
    #1;
    chk("rst_release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("idle_out_valid", out_valid, 0);

    // Single beat, LAST on first beat
    beat(8'h05, 8'h0A, 1'b1);
    expect_result("single", 12'h00F, 1'b0, 12'h00F);
    release_out("single");

    // Four beats of FF/01: carries cross the low/high split
    beat(8'hFF, 8'h01, 1'b0);
    beat(8'hFF, 8'h01, 1'b0);
    beat(8'hFF, 8'h01, 1'b0);
    beat(8'hFF, 8'h01, 1'b1);
    expect_result("four", 12'h400, 1'b0, 12'h000);
    release_out("four");

    // Sign extension: FE+01 and sixteen beats of 80/00
    beat(8'hFE, 8'h01, 1'b1);
    expect_result("sgn1", 12'h0FF, 1'b0, 12'hFFF);
    release_out("sgn1");
    for (int i = 0; i < 15; i++) beat(8'h80, 8'h00, 1'b0);
    beat(8'h80, 8'h00, 1'b1);
    expect_result("sgn16", 12'h800, 1'b0, 12'h800);
    release_out("sgn16");

    // Backpressure in DONE with a pending beat held upstream
    beat(8'h10, 8'h01, 1'b1);
    expect_result("bp1", 12'h011, 1'b0, 12'h011);
    sum_in   = 8'h20;
    carry_in = 8'h02;
    last     = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_data", out_data, 12'h011);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_vld_clr", out_valid, 0);
    chk("bp_in_ready", in_ready, 1);
    chk("bp_data_retained", out_data, 12'h011);
    @(posedge clk); #1;
    in_valid = 1'b0;
    last     = 1'b0;
    expect_result("bp2", 12'h022, 1'b0, 12'h022);
    release_out("bp2");

    // Seventeen beats of FF/00: overflow flag and wrapped sum
    for (int i = 0; i < 16; i++) beat(8'hFF, 8'h00, 1'b0);
    beat(8'hFF, 8'h00, 1'b1);
    expect_result("ovf17", 12'h0EF, 1'b1, 12'hFEF);
    release_out("ovf17");

    // Reset while in R_HI discards the pending result
    beat(8'h11, 8'h22, 1'b0);
    beat(8'h11, 8'h22, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rhi_rst_valid", out_valid, 0);
    chk("rhi_rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("rhi_rst_valid2", out_valid, 0);
    chk("rhi_rst_data", out_data, 0);
    rst_n = 1'b1;
    #1;
    chk("rhi_release_in_ready", in_ready, 1);
    beat(8'h03, 8'h00, 1'b1);
    expect_result("post_rst", 12'h003, 1'b0, 12'h003);
    release_out("post_rst");

    // out_ready with nothing pending is harmless
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_ready_valid", out_valid, 0);
    chk("idle_ready_in_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
